// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage issuing one fetch per cycle into a DEPTH-entry {pc,instr} FIFO feeding decode.
// FETCH_QUEUE_BYPASS_EN: an empty queue forwards the returning word to decode in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_out,
  output logic          pc_en,
  output logic [AW-1:0] im_addr,
  input  logic [DW-1:0] im_DI,
  input  logic          flush,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [AW-1:0] dec_pc,
  output logic [DW-1:0] dec_instr
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] r_mem_pc [DEPTH];
  logic [DW-1:0] r_mem_instr [DEPTH];
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd, r_wr;
  logic          r_inflight;
  logic [AW-1:0] r_pc_q, r_hold_pc;
  logic [DW-1:0] r_hold_instr;
  logic          w_empty, w_push, w_byp, w_pop, w_wr, w_rd, w_issue;
  logic [CW:0]   w_used;
  assign w_empty = r_count == '0;
  assign w_push  = r_inflight & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_empty & w_push;
`else
  assign w_byp = 1'b0;
`endif
  assign dec_valid = ~w_empty | w_byp;
  assign dec_pc    = w_byp ? r_pc_q : (w_empty ? r_hold_pc : r_mem_pc[r_rd]);
  assign dec_instr = w_byp ? im_DI : (w_empty ? r_hold_instr : r_mem_instr[r_rd]);
  assign w_pop   = dec_valid & dec_ready;
  assign w_wr    = w_push & ~(w_byp & dec_ready);
  assign w_rd    = w_pop & ~w_byp;
  // queued entries plus the outstanding fetch must never exceed the FIFO slots
  assign w_used  = {1'b0, r_count} + (CW + 1)'(r_inflight);
  assign w_issue = rst & ~flush & ((w_used < (CW + 1)'(DEPTH)) | w_pop);
  assign pc_en   = rst & (w_issue | flush);
  assign im_addr = pc_out;
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_pc[r_wr]    <= r_pc_q;
      r_mem_instr[r_wr] <= im_DI;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count      <= '0;
      r_rd         <= '0;
      r_wr         <= '0;
      r_inflight   <= 1'b0;
      r_pc_q       <= '0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_pc_q <= pc_out;
      if (dec_valid) begin
        r_hold_pc    <= dec_pc;
        r_hold_instr <= dec_instr;
      end
      if (flush) begin
        r_count <= '0;
        r_rd    <= '0;
        r_wr    <= '0;
      end else begin
        r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        if (w_wr) r_wr <= r_wr + 1'b1;
        if (w_rd) r_rd <= r_rd + 1'b1;
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_wr && !w_rd && r_count == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, directed flush/reset/latency sequences and random traffic against a queue model.
module tb_fetch_queue;
  localparam int DEPTH = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst, pc_en, flush, dec_valid, dec_ready;
  logic [31:0] pc_out, im_addr, im_DI, dec_pc, dec_instr;
  int total = 0, bad = 0;
  logic [63:0] mq[$];
  logic m_inf = 1'b0;
  logic [31:0] m_ipc = '0;
  logic [63:0] m_hold = '0;
  logic a_en, a_valid;
  logic [31:0] a_pc, a_instr;

  fetch_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_en(pc_en), .im_addr(im_addr), .im_DI(im_DI),
    .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic r, f, rdy;
    logic [31:0] tgt;
    logic e_en, e_valid;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  // one clock: drive inputs, predict, compare at negedge, advance model, act as PC and memory
  task automatic cyc(input logic r, input logic f, input logic rdy, input logic [31:0] tgt);
    logic byp, e_valid, pop, issue, e_en;
    logic [63:0] head;
    rst = r;
    flush = f;
    dec_ready = rdy;
    if (!r) begin
      mq.delete();
      m_inf = 1'b0;
      m_hold = '0;
    end
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = r && !f && m_inf && mq.size() == 0;
`endif
    e_valid = mq.size() != 0 || byp;
    head = mq.size() != 0 ? mq[0] : (byp ? {m_ipc, im_DI} : m_hold);
    pop = e_valid && rdy;
    issue = r && !f && ((mq.size() + int'(m_inf)) < DEPTH || pop);
    e_en = issue || (r && f);
    @(negedge clk);
    a_en = pc_en;
    a_valid = dec_valid;
    a_pc = dec_pc;
    a_instr = dec_instr;
    chk("pc_en", 32'(a_en), 32'(e_en));
    chk("dec_valid", 32'(a_valid), 32'(e_valid));
    chk("dec_pc", a_pc, head[63:32]);
    chk("dec_instr", a_instr, head[31:0]);
    chk("im_addr", im_addr, pc_out);
    if (r) begin
      if (f) mq.delete();
      else begin
        if (pop && !byp) void'(mq.pop_front());
        if (m_inf && !(byp && pop)) mq.push_back({m_ipc, im_DI});
      end
      m_inf = issue;
      if (issue) m_ipc = pc_out;
      if (e_valid) m_hold = head;
    end
    @(posedge clk);
    #1;
    im_DI = 32'hA000_0000 | pc_out;
    if (e_en) pc_out = f ? tgt : pc_out + 32'd4;
  endtask

  initial begin
    logic got;
    logic [31:0] got_pc;
    int lat;
    rst = 1'b0;
    flush = 1'b0;
    dec_ready = 1'b0;
    pc_out = '0;
    im_DI = '0;
    //           r f rdy tgt  en valid pc
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
`ifdef FETCH_QUEUE_BYPASS_EN
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h4};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h8};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hC};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h14};
`else
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h4};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h8};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hC};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h10};
`endif
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].rdy, tbl[i].tgt);
      chk($sformatf("tbl%0d_en", i), 32'(a_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_pc", i), a_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), a_instr, tbl[i].e_valid ? (32'hA000_0000 | tbl[i].e_pc) : 32'h0);
    end
    // fill, then redirect to 0x100 with a fetch still outstanding
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h100);
    chk("flush_en", 32'(a_en), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("flush_next_valid", 32'(a_valid), 32'd0);
    got = 1'b0;
    got_pc = '0;
    for (int k = 0; k < 6; k++) begin
      if (!got) begin
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        if (a_valid) begin
          got = 1'b1;
          got_pc = a_pc;
        end
      end
    end
    chk("flush_first_pc", got_pc, 32'h100);
    // flush held for three cycles
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h200);
      chk("hold_flush_en", 32'(a_en), 32'd1);
      if (k > 0) chk("hold_flush_valid", 32'(a_valid), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("post_flush_valid", 32'(a_valid), 32'd0);
    // reset in the middle of a filled queue
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("rst_mid_valid", 32'(a_valid), 32'd0);
    chk("rst_mid_en", 32'(a_en), 32'd0);
    // issue-to-valid latency from an empty queue
    pc_out = 32'h20;
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("lat_issue_en", 32'(a_en), 32'd1);
    lat = 0;
    got_pc = '0;
    for (int k = 1; k <= 6; k++) begin
      if (lat == 0) begin
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        if (a_valid) begin
          lat = k;
          got_pc = a_pc;
        end
      end
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("latency_pc", got_pc, 32'h20);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      logic r, f, rdy;
      r = $urandom_range(99) != 0;
      f = r && $urandom_range(99) < 8;
      rdy = $urandom_range(99) < 65;
      cyc(r, f, rdy, $urandom & 32'h0000_FFFC);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
